// File: rtl/data_mem_mmio_pkg.sv
// rtl/data_mem_mmio_pkg.sv - shared decode and register constants for data_mem_mmio
package data_mem_mmio_pkg;

    localparam logic [1:0] OFF_COUNT   = 2'd0;
    localparam logic [1:0] OFF_COMPARE = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_TXDATA  = 2'd3;

    localparam int ST_PENDING = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;

    localparam logic [3:0] RAM_REGION = 4'h0;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_MMIO
    } region_t;

    // Takes address bits [31:4] and the MMIO base bits [31:4].
    function automatic region_t decode_region(input logic [27:0] addr_hi,
                                              input logic [27:0] base_hi);
        if (addr_hi[27:24] == RAM_REGION) return RGN_RAM;
        if (addr_hi == base_hi) return RGN_MMIO;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// rtl/data_mem_mmio_tx_fifo.sv - synchronous byte FIFO feeding the console TX stream
module data_mem_mmio_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW + 1)'(DEPTH));
    assign empty = (count == '0);

    // Storage is cleared so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data-memory responder: byte-maskable RAM plus timer/console MMIO block
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [31:0] MMIO_BASE      = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        timer_int_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        pending_q;
    logic        ovf_q;

    region_t                 region;
    logic [1:0]              offset;
    logic [RAM_ADDR_WIDTH-1:0] word_idx;
    logic                    wr;
    logic                    rd;
    logic                    mmio_wr;
    logic                    w1c_pending;
    logic                    w1c_ovf;
    logic                    push_req;
    logic                    push_ok;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [31:0]             status;
    logic                    unused_addr_lsb;

    assign region   = decode_region(addr_i[31:4], MMIO_BASE[31:4]);
    assign word_idx = addr_i[RAM_ADDR_WIDTH+1:2];
    assign offset   = addr_i[3:2];
    assign wr       = ce_i && we_i;
    assign rd       = ce_i && !we_i;
    assign mmio_wr  = wr && (region == RGN_MMIO);

    assign w1c_pending = mmio_wr && (offset == OFF_STATUS) && sel_i[0] && data_i[ST_PENDING];
    assign w1c_ovf     = mmio_wr && (offset == OFF_STATUS) && sel_i[0] && data_i[ST_OVF];
    assign push_req    = mmio_wr && (offset == OFF_TXDATA) && sel_i[0];
    assign pop         = !fifo_empty && tx_ready_i;
    // A full FIFO still takes a byte when its head leaves in the same cycle.
    assign push_ok     = push_req && (!fifo_full || pop);

    assign tx_valid_o      = !fifo_empty;
    assign timer_int_o     = pending_q;
    assign unused_addr_lsb = ^addr_i[1:0];

    always_comb begin
        status             = '0;
        status[ST_PENDING] = pending_q;
        status[ST_FULL]    = (fifo_count == CW'(FIFO_DEPTH));
        status[ST_EMPTY]   = fifo_empty;
        status[ST_OVF]     = ovf_q;
    end

    always_comb begin
        data_o = '0;
        if (rd) begin
            case (region)
                RGN_RAM:  data_o = ram[word_idx];
                RGN_MMIO: begin
                    case (offset)
                        OFF_COUNT:   data_o = count_q;
                        OFF_COMPARE: data_o = compare_q;
                        OFF_STATUS:  data_o = status;
                        default:     data_o = '0;
                    endcase
                end
                default:  data_o = '0;
            endcase
        end
    end

    // RAM keeps its contents across reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && wr && (region == RGN_RAM)) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_i[k]) ram[word_idx][8*k +: 8] <= data_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q <= count_q + 32'd1;
            if (mmio_wr && (offset == OFF_COMPARE)) begin
                for (int k = 0; k < 4; k++) begin
                    if (sel_i[k]) compare_q[8*k +: 8] <= data_i[8*k +: 8];
                end
            end
            if ((count_q == compare_q) && (compare_q != '0)) pending_q <= 1'b1;
            else if (w1c_pending)                            pending_q <= 1'b0;
            if (push_req && !push_ok) ovf_q <= 1'b1;
            else if (w1c_ovf)         ovf_q <= 1'b0;
        end
    end

    data_mem_mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (data_i[7:0]),
        .pop       (pop),
        .head      (tx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - directed and randomized checks of data_mem_mmio against a behavioural model
module tb_data_mem_mmio;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MB    = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdata = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] data_o;
    logic        timer_int;
    logic        tx_valid;
    logic [7:0]  tx_data;

    bit [31:0]   m_count;
    bit [31:0]   m_compare;
    bit          m_pending;
    bit          m_ovf;
    logic [7:0]  q[$];
    logic [31:0] ram_m [int];

    int n_pass  = 0;
    int n_total = 0;

    data_mem_mmio dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .we_i        (we),
        .addr_i      (addr),
        .sel_i       (sel),
        .data_i      (wdata),
        .data_o      (data_o),
        .timer_int_o (timer_int),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:28] == 4'h0) return ram_m[int'(a[11:2])];
        if (a[31:4] == MB[31:4]) begin
            case (a[3:2])
                2'd0: return m_count;
                2'd1: return m_compare;
                2'd2: return {28'b0, m_ovf, q.size() == 0, q.size() == DEPTH, m_pending};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_pending = 0; m_ovf = 0;
        q.delete();
    endtask

    // One clock edge: compute next model state from the presented request, then compare.
    task automatic step();
        bit [31:0]   cnt_n, cmp_n;
        bit          pend_n, ovf_n, do_pop, push_req, acc, is_ram, is_mmio;
        logic [1:0]  off;
        logic [31:0] w;
        int          idx;
        cnt_n    = m_count + 1;
        cmp_n    = m_compare;
        pend_n   = m_pending;
        ovf_n    = m_ovf;
        is_ram   = ce && we && (addr[31:28] == 4'h0);
        is_mmio  = ce && we && (addr[31:4] == MB[31:4]);
        off      = addr[3:2];
        do_pop   = (q.size() > 0) && tx_ready;
        push_req = is_mmio && (off == 2'd3) && sel[0];
        acc      = push_req && ((q.size() < DEPTH) || do_pop);
        if (is_mmio && off == 2'd1)
            for (int k = 0; k < 4; k++) if (sel[k]) cmp_n[8*k +: 8] = wdata[8*k +: 8];
        if (is_mmio && off == 2'd2 && sel[0] && wdata[0]) pend_n = 0;
        if (m_count == m_compare && m_compare != 0) pend_n = 1;
        if (is_mmio && off == 2'd2 && sel[0] && wdata[3]) ovf_n = 0;
        if (push_req && !acc) ovf_n = 1;
        if (is_ram) begin
            idx = int'(addr[11:2]);
            w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
            for (int k = 0; k < 4; k++) if (sel[k]) w[8*k +: 8] = wdata[8*k +: 8];
            ram_m[idx] = w;
        end
        @(posedge clk);
        #1;
        m_count = cnt_n; m_compare = cmp_n; m_pending = pend_n; m_ovf = ovf_n;
        if (do_pop) void'(q.pop_front());
        if (acc) q.push_back(wdata[7:0]);
        chk("timer_int", 32'(timer_int), 32'(m_pending));
        chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("tx_data", {24'b0, tx_data}, {24'b0, q[0]});
    endtask

    task automatic idle();
        ce = 0; we = 0;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        ce = 1; we = 1; addr = a; sel = s; wdata = d;
        #1;
        chk("data_o_on_write", data_o, 32'h0);
        step();
        ce = 0; we = 0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        ce = 1; we = 0; addr = a; sel = 4'($urandom); wdata = $urandom;
        #1;
        chk(tag, data_o, m_read(a));
        step();
        ce = 0;
    endtask

    function automatic logic [31:0] ram_addr(input int idx);
        logic [31:0] r;
        r = $urandom;
        return {4'h0, r[15:0], idx[9:0], r[17:16]};
    endfunction

    initial begin
        logic [7:0]  exp4 [4];
        logic [31:0] c;
        int          r;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_timer", 32'(timer_int), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        rst = 0;
        model_reset();

        // Timer compare written first so COUNT==20 lands well after setup
        wr(MB + 4, 4'b1111, 32'd20);

        // Lane masking
        wr(32'h0000_0010, 4'b1111, 32'hAABB_CCDD);
        wr(32'h0000_0010, 4'b1000, 32'h1122_3344);
        ce = 1; we = 0; addr = 32'h10; #1;
        chk("lane_mask", data_o, 32'h11BB_CCDD);
        ce = 0; #1;
        chk("ce_off_read", data_o, 32'h0);
        step();

        // Timer rise, W1C clear, and set-beats-clear
        for (int i = 0; i < 100 && m_count != 20; i++) idle();
        ce = 1; we = 0; addr = MB; #1;
        chk("count_at_20", data_o, 32'd20);
        chk("timer_before_rise", 32'(timer_int), 32'h0);
        step();
        ce = 0;
        chk("timer_rise", 32'(timer_int), 32'h1);
        wr(MB + 8, 4'b0001, 32'h1);
        chk("timer_w1c", 32'(timer_int), 32'h0);
        c = m_count + 4;
        wr(MB + 4, 4'b1111, c);
        for (int i = 0; i < 20 && m_count != c; i++) idle();
        wr(MB + 8, 4'b0001, 32'h1);
        chk("timer_set_wins", 32'(timer_int), 32'h1);
        wr(MB + 8, 4'b0001, 32'h1);
        chk("timer_cleared", 32'(timer_int), 32'h0);

        // FIFO fill past depth, then drain
        tx_ready = 0;
        for (int i = 0; i < 5; i++) wr(MB + 12, 4'b0001, 32'h41 + i);
        ce = 1; we = 0; addr = MB + 8; #1;
        chk("status_full_ovf", data_o, 32'hA);
        ce = 0;
        step();
        tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", {24'b0, tx_data}, 32'h41 + i);
            step();
        end
        ce = 1; we = 0; addr = MB + 8; #1;
        chk("status_empty", data_o, 32'hC);
        ce = 0;
        step();
        wr(MB + 8, 4'b0001, 32'h8);

        // Full FIFO with a simultaneous pop accepts the push
        tx_ready = 0;
        for (int i = 0; i < 4; i++) wr(MB + 12, 4'b0001, 32'h51 + i);
        tx_ready = 1;
        wr(MB + 12, 4'b0001, 32'h55);
        exp4 = '{8'h52, 8'h53, 8'h54, 8'h55};
        for (int i = 0; i < 4; i++) begin
            chk("full_pop_order", {24'b0, tx_data}, {24'b0, exp4[i]});
            idle();
        end
        ce = 1; we = 0; addr = MB + 8; #1;
        chk("status_no_ovf", data_o, 32'h4);
        ce = 0;
        step();

        // Unmapped access
        wr(32'h2000_0000, 4'b1111, 32'hDEAD_BEEF);
        rd(32'h2000_0000, "unmapped_read");
        rd(32'h0000_0010, "ram_after_unmapped");
        rd(MB + 4, "compare_after_unmapped");

        // Randomized traffic against the model
        for (int i = 16; i < 32; i++) wr(ram_addr(i), 4'b1111, $urandom);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 10);
            tx_ready = 1'($urandom_range(0, 1));
            case (r)
                0, 1: wr(ram_addr(16 + $urandom_range(0, 15)), 4'($urandom), $urandom);
                2, 3: rd(ram_addr(16 + $urandom_range(0, 15)), "rnd_ram");
                4:    rd(MB + 32'($urandom_range(0, 3) * 4), "rnd_mmio");
                5:    wr(MB + 12, 4'($urandom), $urandom);
                6:    wr(MB + 8, 4'($urandom), $urandom);
                7:    wr(MB + 4, 4'($urandom), m_count + $urandom_range(1, 12));
                8:    wr(32'h2000_0000 + ($urandom & 32'h0FFF_FFFF), 4'b1111, $urandom);
                9:    rd(MB + 32'h10, "rnd_unmapped");
                default: wr(MB, 4'b1111, $urandom);
            endcase
        end

        // Reset mid-burst
        tx_ready = 1;
        for (int i = 0; i < 6; i++) idle();
        wr(MB + 8, 4'b0001, 32'h9);
        tx_ready = 0;
        for (int i = 0; i < 3; i++) wr(MB + 12, 4'b0001, 32'h61 + i);
        wr(MB + 4, 4'b1111, m_count + 3);
        for (int i = 0; i < 20 && !m_pending; i++) idle();
        chk("pre_rst_pending", 32'(timer_int), 32'h1);
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
        ce = 1; we = 1; addr = 32'h10; sel = 4'b1111; wdata = 32'h0;
        #2;
        rst = 1;
        #1;
        chk("async_rst_valid", 32'(tx_valid), 32'h0);
        chk("async_rst_timer", 32'(timer_int), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        ce = 0; we = 0; rst = 0;
        model_reset();
        ce = 1; addr = MB; #1;
        chk("count_after_rst", data_o, 32'h0);
        addr = 32'h10; #1;
        chk("ram_kept", data_o, 32'h11BB_CCDD);
        ce = 0;
        step();
        rd(MB + 4, "compare_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Responder on the CPU core's data-memory port. It answers the ce/we/sel/addr/data requests issued by the core's memory stage.
- A byte-maskable data RAM region.
- A small MMIO region with a free-running cycle counter, a compare timer with interrupt, and a console TX byte FIFO drained by a valid/ready handshake.
- Reads are combinational because the core samples read data in the same cycle. All state updates happen on the clock edge.

Parameters:
RAM_ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
MMIO_BASE, 32'h1000_0000, base address of the MMIO register block.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
ce_i  in  1  request valid this cycle.
we_i  in  1  1 = write, 0 = read.
addr_i  in  32  byte address; bits [1:0] ignored.
sel_i  in  4  byte-lane enables; big-endian, sel_i[3] selects data[31:24] (byte address offset 0).
data_i  in  32  write data.
data_o  out  32  read data, combinational.
timer_int_o  out  1  timer pending flag (level).
tx_valid_o  out  1  FIFO not empty.
tx_data_o  out  8  FIFO head byte.
tx_ready_i  in  1  consumer accepts head; pop when tx_valid_o && tx_ready_i.

Behaviour:
- Address decode:
  - RAM hit: addr_i[31:28]==4'h0. Word index = addr_i[RAM_ADDR_WIDTH+1:2]; higher bits alias.
  - MMIO hit: addr_i[31:4]==MMIO_BASE[31:4]. Register offset = addr_i[3:2].
  - Anything else is unmapped: reads return 0, writes are ignored.
- Reads:
  - ce_i=0 or we_i=1: data_o = 0.
  - Reads return the full word regardless of sel_i; the core extracts bytes itself.
  - Reads have no side effects, including the FIFO.
- RAM writes: on the clock edge when ce_i && we_i, each lane with sel_i[k]=1 is updated; other lanes are held. RAM contents are not reset.
- MMIO registers (offsets):
  - 0x0 COUNT, RO: 32-bit cycle counter, increments every cycle, wraps FFFF_FFFF -> 0. Writes ignored.
  - 0x4 COMPARE, RW: byte-maskable write per sel_i.
  - 0x8 STATUS:
    - bit0 timer_pending, W1C.
    - bit1 fifo_full, RO.
    - bit2 fifo_empty, RO.
    - bit3 tx_overflow, sticky, W1C.
    - Other bits read 0.
    - W1C takes effect only when sel_i[0]=1.
  - 0xC TXDATA, WO (reads 0): a write with sel_i[0]=1 pushes data_i[7:0].
- Timer:
  - When COUNT==COMPARE and COMPARE!=0, timer_pending is set at the next edge.
  - If a set condition and a W1C of bit0 occur in the same cycle, set wins.
  - timer_int_o = timer_pending.
- FIFO:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Simultaneous push+pop keeps the count unchanged.
  - A rejected push drops the byte and sets tx_overflow. If a W1C of bit3 happens in the same cycle, the set wins.
  - Pop on an empty FIFO is impossible because tx_valid_o=0.
  - Read/write pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
  - tx_data_o = head entry, updated the cycle after a pop or after the first push into an empty FIFO.
- Reset values:
  - COUNT=0, COMPARE=0, timer_pending=0, tx_overflow=0.
  - FIFO empty: tx_valid_o=0, tx_data_o=0.
  - timer_int_o=0; data_o=0 while ce_i=0.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). A write presented in the same cycle as reset is discarded; RAM is unaffected by reset itself.

Decomposition:
- Shared package: MMIO offset constants (OFF_COUNT/OFF_COMPARE/OFF_STATUS/OFF_TXDATA), STATUS bit indices, RAM/MMIO region-select constants.
- One natural sub-module: tx_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count outputs. Decode, RAM array, counter/timer and STATUS logic stay in data_mem_mmio.

Test Plan:
1. Lane masking: write 0x0000_0010 with data 0xAABBCCDD, sel 4'b1111; then write data 0x11xxxxxx, sel 4'b1000 -> read of 0x10 returns 0x11BBCCDD; read with ce_i=0 returns 0.
2. Timer: write COMPARE=20 after reset -> timer_int_o rises the cycle after COUNT reads 20. A W1C of STATUS bit0 clears it; a W1C issued on a set cycle leaves it set.
3. FIFO fill/drain: with tx_ready_i=0, push 0x41..0x45 (5 pushes, depth 4) -> STATUS=0b1010 (full, overflow); raise tx_ready_i -> bytes 0x41,0x42,0x43,0x44 emitted in order, then STATUS bit2=1.
4. Full with simultaneous pop: FIFO full, tx_ready_i=1, push 0x55 -> accepted, no overflow, 0x55 emitted last.
5. Unmapped access: write 0x2000_0000 and read it -> data_o=0; no RAM or MMIO state changes.
6. Reset mid-burst: assert rst while the FIFO holds 3 bytes and timer_pending=1 -> tx_valid_o=0, timer_int_o=0, COUNT reads 0 after release; RAM word written before reset is still intact.
